// File: rtl/windowed_integrator_if.sv
// windowed_integrator_if
//   Bundles the sample stream and the result signals of windowed_integrator.
//   clk and reset stay plain ports on the block.
//   Signals:
//     clear    : window abort request (master -> slave)
//     x_valid  : x carries a sample this cycle (master -> slave)
//     x        : unsigned sample, XW bits (master -> slave)
//     y        : result of the last completed window, ACCW bits (slave -> master)
//     y_valid  : one-cycle pulse marking a new y (slave -> master)
//     ovf      : the window reported on y overflowed (slave -> master)
//     busy     : a window is partially filled (slave -> master)
//   Modports: master drives samples, slave is the integrator.
interface windowed_integrator_if #(
  parameter int XW   = 4,
  parameter int ACCW = 13
);
  logic            clear;
  logic            x_valid;
  logic [XW-1:0]   x;
  logic [ACCW-1:0] y;
  logic            y_valid;
  logic            ovf;
  logic            busy;

  modport master (
    output clear, x_valid, x,
    input  y, y_valid, ovf, busy
  );

  modport slave (
    input  clear, x_valid, x,
    output y, y_valid, ovf, busy
  );
endinterface

// File: rtl/windowed_integrator.sv
// windowed_integrator
//   Accumulates x*COEF over windows of WIN accepted samples and reports the
//   window sum on y with a one-cycle y_valid pulse, one clock after the last
//   sample. Accumulation either saturates at 2^ACCW-1 (SAT=1) or wraps
//   modulo 2^ACCW (SAT=0); ovf flags a window whose exact sum exceeded ACCW.
//   Ports:
//     clk   : clock, rising edge
//     reset : synchronous active-high reset (beats clear and x_valid)
//     bus   : windowed_integrator_if slave (clear, x_valid, x -> y, y_valid,
//             ovf, busy)
module windowed_integrator #(
  parameter int XW   = 4,
  parameter int COEF = 25,
  parameter int WIN  = 8,
  parameter int ACCW = 13,
  parameter int SAT  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  windowed_integrator_if.slave   bus
);

  // Exact product width, and a sum width with one spare bit above the larger
  // of accumulator and product so acc + p never loses its carry.
  localparam int PW = XW + $clog2(COEF + 1);
  localparam int SW = ((ACCW > PW) ? ACCW : PW) + 1;
  localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;

  localparam logic [SW-1:0] COEF_W  = SW'(COEF);
  localparam logic [SW-1:0] MAX_W   = {{(SW-ACCW){1'b0}}, {ACCW{1'b1}}};
  localparam logic [CW-1:0] LAST_CNT = CW'(WIN - 1);

  typedef enum logic [0:0] {IDLE, ACCUM} state_t;

  state_t          state_q,    state_d;
  logic [ACCW-1:0] acc_q,      acc_d;
  logic [CW-1:0]   cnt_q,      cnt_d;
  logic            oflag_q,    oflag_d;
  logic [ACCW-1:0] y_q,        y_d;
  logic            y_valid_q,  y_valid_d;
  logic            ovf_q,      ovf_d;

  logic [SW-1:0]   prod;
  logic [SW-1:0]   sum;
  logic            sum_over;
  logic [ACCW-1:0] acc_next;

  always_comb begin
    prod     = {{(SW-XW){1'b0}}, bus.x} * COEF_W;
    sum      = {{(SW-ACCW){1'b0}}, acc_q} + prod;
    sum_over = (sum > MAX_W);
    if (sum_over && (SAT != 0)) begin
      acc_next = {ACCW{1'b1}};
    end else begin
      acc_next = sum[ACCW-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    oflag_d   = oflag_q;
    y_d       = y_q;
    ovf_d     = ovf_q;
    y_valid_d = 1'b0;

    if (bus.clear) begin
      // Abort drops the partial window; y and ovf keep the last report.
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      oflag_d = 1'b0;
    end else if (bus.x_valid) begin
      if (cnt_q == LAST_CNT) begin
        // Closing sample: publish and restart in the same edge.
        y_d       = acc_next;
        ovf_d     = oflag_q | sum_over;
        y_valid_d = 1'b1;
        state_d   = IDLE;
        acc_d     = '0;
        cnt_d     = '0;
        oflag_d   = 1'b0;
      end else begin
        state_d = ACCUM;
        acc_d   = acc_next;
        cnt_d   = cnt_q + CW'(1);
        oflag_d = oflag_q | sum_over;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      oflag_q   <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      oflag_q   <= oflag_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.ovf     = ovf_q;
  assign bus.busy    = (state_q == ACCUM);

endmodule

// File: tb/tb_windowed_integrator.sv
// tb_windowed_integrator
//   Directed vectors against four integrator instances sharing one stimulus:
//     u_def : defaults (ACCW=13, SAT=1, WIN=8)
//     u_sat : ACCW=10, SAT=1
//     u_wrp : ACCW=10, SAT=0
//     u_w1  : WIN=1
module tb_windowed_integrator;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       xv;
  logic [3:0] xs;

  int vectors     = 0;
  int miscompares = 0;
  int pulses_def  = 0;

  always #5 clk = ~clk;

  windowed_integrator_if #(.XW(4), .ACCW(13)) if_def ();
  windowed_integrator_if #(.XW(4), .ACCW(10)) if_sat ();
  windowed_integrator_if #(.XW(4), .ACCW(10)) if_wrp ();
  windowed_integrator_if #(.XW(4), .ACCW(13)) if_w1  ();

  assign if_def.clear = clear;  assign if_def.x_valid = xv;  assign if_def.x = xs;
  assign if_sat.clear = clear;  assign if_sat.x_valid = xv;  assign if_sat.x = xs;
  assign if_wrp.clear = clear;  assign if_wrp.x_valid = xv;  assign if_wrp.x = xs;
  assign if_w1.clear  = clear;  assign if_w1.x_valid  = xv;  assign if_w1.x  = xs;

  windowed_integrator #(.XW(4), .COEF(25), .WIN(8), .ACCW(13), .SAT(1))
    u_def (.clk(clk), .reset(reset), .bus(if_def.slave));
  windowed_integrator #(.XW(4), .COEF(25), .WIN(8), .ACCW(10), .SAT(1))
    u_sat (.clk(clk), .reset(reset), .bus(if_sat.slave));
  windowed_integrator #(.XW(4), .COEF(25), .WIN(8), .ACCW(10), .SAT(0))
    u_wrp (.clk(clk), .reset(reset), .bus(if_wrp.slave));
  windowed_integrator #(.XW(4), .COEF(25), .WIN(1), .ACCW(13), .SAT(1))
    u_w1  (.clk(clk), .reset(reset), .bus(if_w1.slave));

  // Pulse counter for the default instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (if_def.y_valid === 1'b1) pulses_def++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one edge; outputs are observed 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] v);
    xv = 1'b1;
    xs = v;
    tick();
    xv = 1'b0;
  endtask

  task automatic idle(input int n);
    xv = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  int p0;

  initial begin
    reset = 1'b1; clear = 1'b0; xv = 1'b0; xs = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_y",       32'(if_def.y), 0);
    check("rst_y_valid", 32'(if_def.y_valid), 0);
    check("rst_ovf",     32'(if_def.ovf), 0);
    check("rst_busy",    32'(if_def.busy), 0);
    idle(1);

    // 8 x 15: 3000 exact; 1023 saturated; 3000 mod 1024 = 952 wrapped
    for (int i = 0; i < 8; i++) begin
      send(4'd15);
      if (i < 7) begin
        check($sformatf("w1_busy_%0d", i), 32'(if_def.busy), 1);
        check($sformatf("w1_novalid_%0d", i), 32'(if_def.y_valid), 0);
      end
      if (i == 0) begin
        check("win1_y", 32'(if_w1.y), 375);
        check("win1_valid", 32'(if_w1.y_valid), 1);
      end
    end
    check("w1_y_valid", 32'(if_def.y_valid), 1);
    check("w1_y",       32'(if_def.y), 3000);
    check("w1_ovf",     32'(if_def.ovf), 0);
    check("w1_busy",    32'(if_def.busy), 0);
    check("sat_y",      32'(if_sat.y), 1023);
    check("sat_ovf",    32'(if_sat.ovf), 1);
    check("wrp_y",      32'(if_wrp.y), 952);
    check("wrp_ovf",    32'(if_wrp.ovf), 1);
    check("win1_valid_consec", 32'(if_w1.y_valid), 1);

    // Back-to-back follow-on window of x=1: 200, ovf cleared
    for (int i = 0; i < 8; i++) send(4'd1);
    check("sat2_y",     32'(if_sat.y), 200);
    check("sat2_ovf",   32'(if_sat.ovf), 0);
    check("def2_y",     32'(if_def.y), 200);
    check("def2_valid", 32'(if_def.y_valid), 1);
    idle(1);
    check("def2_valid_drop", 32'(if_def.y_valid), 0);
    check("def2_y_hold",     32'(if_def.y), 200);

    // x = 0..7 with 1-3 idle cycles between: 28*25 = 700, one pulse
    p0 = pulses_def;
    for (int v = 0; v < 8; v++) begin
      send(4'(v));
      check($sformatf("win1_y_x%0d", v), 32'(if_w1.y), 32'(v * 25));
      if (v == 7) check("gap_y_valid", 32'(if_def.y_valid), 1);
      idle((v % 3) + 1);
    end
    check("gap_y",      32'(if_def.y), 700);
    check("gap_pulses", 32'(pulses_def - p0), 1);

    // 5 x 15, then clear with x_valid, then 8 x 2 -> 400
    p0 = pulses_def;
    for (int i = 0; i < 5; i++) send(4'd15);
    clear = 1'b1; xv = 1'b1; xs = 4'd15;
    tick();
    clear = 1'b0; xv = 1'b0;
    check("clr_no_valid", 32'(if_def.y_valid), 0);
    check("clr_busy",     32'(if_def.busy), 0);
    check("clr_y_hold",   32'(if_def.y), 700);
    check("clr_sat_ovf_hold", 32'(if_sat.ovf), 0);
    for (int i = 0; i < 8; i++) begin
      send(4'd2);
      if (i == 6) check("clr_y_still", 32'(if_def.y), 700);
    end
    check("clr_y",        32'(if_def.y), 400);
    check("clr_valid",    32'(if_def.y_valid), 1);
    check("clr_sat_y",    32'(if_sat.y), 400);
    check("clr_sat_ovf",  32'(if_sat.ovf), 0);
    idle(1);
    check("clr_pulses",   32'(pulses_def - p0), 1);

    // Reset mid-window, then 16 x 1 -> two windows of 200
    p0 = pulses_def;
    for (int i = 0; i < 4; i++) send(4'd9);
    reset = 1'b1; xv = 1'b1; xs = 4'd9; clear = 1'b1;
    tick();
    reset = 1'b0; xv = 1'b0; clear = 1'b0;
    check("mid_rst_y",     32'(if_def.y), 0);
    check("mid_rst_busy",  32'(if_def.busy), 0);
    check("mid_rst_valid", 32'(if_def.y_valid), 0);
    check("mid_rst_ovf",   32'(if_wrp.ovf), 0);
    idle(1);
    check("mid_rst_pulses", 32'(pulses_def - p0), 0);
    p0 = pulses_def;
    for (int i = 0; i < 16; i++) begin
      send(4'd1);
      if (i == 7) check("b2b_y_first", 32'(if_def.y), 200);
    end
    check("b2b_y_second", 32'(if_def.y), 200);
    idle(2);
    check("b2b_pulses",   32'(pulses_def - p0), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
